joybus_host_master: RTL and testbench

- Host/initiator end of the N64 Joybus single-wire protocol; the console/PIF side that talks to a controller-side responder.
- Serialises a command of 1..MAX_TX bytes onto the open-drain line, sends the host stop bit, releases the line, then decodes up to MAX_RX response bytes from the device.
- Sits between the PIF command engine (byte-stream interface) and the controller port pad.

---
 rtl/joybus_host_master.sv | 233 +++++++++++++++++++++++
 tb/tb_joybus_host_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joybus_host_master.sv
// N64 Joybus host master: serialises a command onto the open-drain line, then decodes the reply.
// Optional JOYBUS_GLITCH_FILTER_EN: 3-sample glitch filter on the synchronised line level.
module joybus_host_master #(
    parameter int unsigned T1US       = 50,
    parameter int unsigned RX_TIMEOUT = 3200,
    parameter int unsigned MAX_TX     = 63,
    parameter int unsigned MAX_RX     = 63
) (
    input  logic                            clock,
    input  logic                            reset_l,
    input  logic                            start,
    input  logic [$clog2(MAX_TX+1)-1:0]     tx_len,
    input  logic [$clog2(MAX_RX+1)-1:0]     rx_len,
    input  logic [7:0]                      tx_data,
    output logic                            tx_ack,
    output logic [7:0]                      rx_data,
    output logic                            rx_valid,
    output logic [$clog2(MAX_RX+1)-1:0]     rx_count,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout_err,
    input  logic                            jb_in,
    output logic                            jb_oe
);
    localparam int unsigned TxW  = $clog2(MAX_TX + 1);
    localparam int unsigned RxW  = $clog2(MAX_RX + 1);
    localparam int unsigned CntW = 16;
    localparam logic [CntW-1:0] T1   = CntW'(T1US);
    localparam logic [CntW-1:0] T2   = CntW'(2 * T1US);
    localparam logic [CntW-1:0] T3   = CntW'(3 * T1US);
    localparam logic [CntW-1:0] T4   = CntW'(4 * T1US);
    localparam logic [CntW-1:0] T8   = CntW'(8 * T1US);
    localparam logic [CntW-1:0] TOut = CntW'(RX_TIMEOUT);
    localparam logic [CntW-1:0] One  = CntW'(1);

    typedef enum logic [3:0] {
        StIdle, StTxLow, StTxHigh, StTxStop, StStopWait,
        StRxWait, StRxLow, StRxStop, StRxStopLow, StDone, StErr
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      tx_sh_q, tx_sh_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [TxW-1:0]  tx_left_q, tx_left_d;
    logic [RxW-1:0]  rx_len_q, rx_len_d;
    logic [6:0]      rx_sh_q, rx_sh_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic [RxW-1:0]  rx_count_q, rx_count_d;
    logic            rx_valid_q, rx_valid_d;
    logic            tx_ack_q, tx_ack_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            terr_q, terr_d;
    logic            jb_oe_q, jb_oe_d;
    logic            sync1_q, sync2_q, lvl_prev_q;
    logic            level, fall, rise;
    logic [CntW-1:0] low_len;
    logic            rx_bit;

`ifdef JOYBUS_GLITCH_FILTER_EN
    logic h1_q, h2_q, filt_q;
    // A new level is accepted once three consecutive synchronised samples agree.
    always_comb level = (sync2_q == h1_q && h1_q == h2_q) ? sync2_q : filt_q;
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            h1_q   <= 1'b1;
            h2_q   <= 1'b1;
            filt_q <= 1'b1;
        end else begin
            h1_q   <= sync2_q;
            h2_q   <= h1_q;
            filt_q <= level;
        end
    end
`else
    always_comb level = sync2_q;
`endif

    assign fall    = lvl_prev_q & ~level;
    assign rise    = ~lvl_prev_q & level;
    assign low_len = tx_sh_q[7] ? T1 : T3;
    assign rx_bit  = (cnt_q < T2);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + One;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_left_d  = tx_left_q;
        rx_len_d   = rx_len_q;
        rx_sh_d    = rx_sh_q;
        rx_bit_d   = rx_bit_q;
        rx_data_d  = rx_data_q;
        rx_count_d = rx_count_q;
        rx_valid_d = 1'b0;
        tx_ack_d   = 1'b0;
        terr_d     = terr_q;
        case (state_q)
            StIdle, StDone, StErr: begin
                state_d = StIdle;
                cnt_d   = '0;
                if (start) begin
                    terr_d     = 1'b0;
                    rx_count_d = '0;
                    rx_bit_d   = '0;
                    if (tx_len == '0) begin
                        state_d = StDone;
                    end else begin
                        tx_left_d = tx_len;
                        rx_len_d  = rx_len;
                        tx_sh_d   = tx_data;
                        tx_bit_d  = '0;
                        tx_ack_d  = 1'b1;
                        state_d   = StTxLow;
                    end
                end
            end
            StTxLow: if (cnt_q == low_len - One) begin
                cnt_d   = '0;
                state_d = StTxHigh;
            end
            StTxHigh: if (cnt_q == T4 - low_len - One) begin
                cnt_d    = '0;
                tx_bit_d = tx_bit_q + 3'd1;
                tx_sh_d  = {tx_sh_q[6:0], 1'b0};
                state_d  = StTxLow;
                if (tx_bit_q == 3'd7) begin
                    if (tx_left_q == TxW'(1)) begin
                        state_d = StTxStop;
                    end else begin
                        tx_left_d = tx_left_q - TxW'(1);
                        tx_sh_d   = tx_data;
                        tx_ack_d  = 1'b1;
                    end
                end
            end
            StTxStop: if (cnt_q == T1 - One) begin
                cnt_d   = '0;
                state_d = (rx_len_q == '0) ? StStopWait : StRxWait;
            end
            StStopWait: if (cnt_q == T2 - One) state_d = StDone;
            StRxWait, StRxStop: begin
                if (fall) begin
                    // The cycle that revealed the falling edge is already one low cycle.
                    cnt_d   = One;
                    state_d = (state_q == StRxWait) ? StRxLow : StRxStopLow;
                end else if (cnt_q == TOut - One) begin
                    state_d = StErr;
                end
            end
            StRxLow: begin
                if (rise) begin
                    cnt_d    = '0;
                    state_d  = StRxWait;
                    rx_sh_d  = {rx_sh_q[5:0], rx_bit};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_data_d  = {rx_sh_q, rx_bit};
                        rx_valid_d = 1'b1;
                        rx_count_d = rx_count_q + RxW'(1);
                        if (rx_count_d == rx_len_q) state_d = StRxStop;
                    end
                end else if (cnt_q == T8) begin
                    state_d = StErr;
                end
            end
            StRxStopLow: begin
                if (rise) state_d = StDone;
                else if (cnt_q == T8) state_d = StErr;
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StErr) terr_d = 1'b1;
        busy_d  = !(state_d inside {StIdle, StDone, StErr});
        done_d  = (state_d == StDone) || (state_d == StErr);
        jb_oe_d = (state_d == StTxLow) || (state_d == StTxStop);
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tx_sh_q    <= '0;
            tx_bit_q   <= '0;
            tx_left_q  <= '0;
            rx_len_q   <= '0;
            rx_sh_q    <= '0;
            rx_bit_q   <= '0;
            rx_data_q  <= '0;
            rx_count_q <= '0;
            rx_valid_q <= 1'b0;
            tx_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
            jb_oe_q    <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            lvl_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_left_q  <= tx_left_d;
            rx_len_q   <= rx_len_d;
            rx_sh_q    <= rx_sh_d;
            rx_bit_q   <= rx_bit_d;
            rx_data_q  <= rx_data_d;
            rx_count_q <= rx_count_d;
            rx_valid_q <= rx_valid_d;
            tx_ack_q   <= tx_ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            terr_q     <= terr_d;
            jb_oe_q    <= jb_oe_d;
            sync1_q    <= jb_in;
            sync2_q    <= sync1_q;
            lvl_prev_q <= level;
        end
    end

    assign tx_ack      = tx_ack_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_count    = rx_count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign jb_oe       = jb_oe_q;
endmodule

// File: tb/tb_joybus_host_master.sv
// Bench for joybus_host_master: table of transactions plus random ones, device modelled on the line.
module tb_joybus_host_master;
`ifdef JOYBUS_GLITCH_FILTER_EN
    localparam bit FiltOn = 1'b1;
`else
    localparam bit FiltOn = 1'b0;
`endif
    localparam int Budget = 20000;

    logic       clock = 1'b0;
    logic       reset_l = 1'b0;
    logic       start = 1'b0;
    logic [5:0] tx_len = '0;
    logic [5:0] rx_len = '0;
    logic [7:0] tx_data = '0;
    logic       tx_ack, rx_valid, busy, done, timeout_err, jb_oe;
    logic [7:0] rx_data;
    logic [5:0] rx_count;
    logic       dev_drive = 1'b0;
    wire        jb_in = !(jb_oe || dev_drive);

    joybus_host_master dut (
        .clock(clock), .reset_l(reset_l), .start(start), .tx_len(tx_len), .rx_len(rx_len),
        .tx_data(tx_data), .tx_ack(tx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_count(rx_count), .busy(busy), .done(done), .timeout_err(timeout_err),
        .jb_in(jb_in), .jb_oe(jb_oe)
    );

    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          tx_len;
        logic [23:0] tx;
        int          rx_len;
        int          n_dev;
        logic [23:0] dev;
        int          lw1;
        int          lw0;
        bit          glitch;
        bit          poke;
        int          exp_count;
        bit          exp_err;
        logic [7:0]  exp_last;
    } vec_t;

    int total = 0;
    int bad = 0;
    int runs[$], starts[$], acks[$];
    logic [7:0] rxq[$], expq[$];
    int  done_cyc, rel_cyc, start_cyc, m_cnt;
    bit  done_seen, busy_ever, fin, m_err;
    int  d_count;
    bit  d_err, d_busy, d_oe;
    logic [7:0] d_data;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [23:0] w, input int i);
        logic [23:0] s;
        s = w >> (8 * (2 - i));
        return s[7:0];
    endfunction

    // Reference: turn the device waveform into a bit stream by the width rule, then into bytes.
    task automatic model(input vec_t v);
        bit bits[$];
        logic [7:0] b;
        int w, groups;
        expq = {};
        bits = {};
        if (v.glitch && !FiltOn) bits.push_back(1'b1);
        for (int i = 0; i < v.n_dev; i++) begin
            b = byte_of(v.dev, i);
            for (int j = 7; j >= 0; j--) begin
                w = b[j] ? v.lw1 : v.lw0;
                bits.push_back(w < 100);
            end
        end
        if (v.n_dev > 0) bits.push_back(1'b1);  // device stop pulse, 50 cycles low
        groups = bits.size() / 8;
        m_cnt = (groups < v.rx_len) ? groups : v.rx_len;
        m_err = (v.tx_len > 0) && (v.rx_len > 0) && (bits.size() < 8 * v.rx_len + 1);
        if (v.tx_len == 0) begin
            m_cnt = 0;
            m_err = 1'b0;
        end
        for (int g = 0; g < m_cnt; g++) begin
            for (int k = 0; k < 8; k++) b[7-k] = bits[8*g+k];
            expq.push_back(b);
        end
    endtask

    task automatic pulse(input int lo, input int hi);
        dev_drive = 1'b1;
        repeat (lo) @(negedge clock);
        dev_drive = 1'b0;
        repeat (hi) @(negedge clock);
    endtask

    task automatic run_txn(input vec_t v, input string name);
        int werr, aerr, want_w, d, k;
        logic [7:0] b;
        runs = {}; starts = {}; acks = {}; rxq = {};
        done_seen = 0; busy_ever = 0; fin = 0; k = 1;
        model(v);
        fork
            begin
                @(negedge clock);
                tx_len = 6'(v.tx_len); rx_len = 6'(v.rx_len); tx_data = byte_of(v.tx, 0);
                start = 1'b1; start_cyc = cyc;
                @(negedge clock);
                while (!fin) begin
                    start = 1'b0;
                    if (v.poke && cyc == start_cyc + 500) begin
                        start = 1'b1; tx_len = 6'd7; rx_len = 6'd0;
                    end
                    if (tx_ack && k < 3) begin
                        tx_data = byte_of(v.tx, k);
                        k++;
                    end
                    @(negedge clock);
                end
                start = 1'b0;
            end
            begin
                bit prev;
                int rs, bud;
                prev = 0; rs = 0; bud = 0;
                while (!fin) begin
                    @(negedge clock);
                    if (jb_oe && !prev) rs = cyc;
                    if (!jb_oe && prev) begin
                        runs.push_back(cyc - rs); starts.push_back(rs); rel_cyc = cyc;
                    end
                    prev = jb_oe;
                    if (busy) busy_ever = 1;
                    if (tx_ack) acks.push_back(cyc);
                    if (rx_valid) rxq.push_back(rx_data);
                    if (done) begin
                        done_seen = 1; done_cyc = cyc; d_count = int'(rx_count);
                        d_err = timeout_err; d_busy = busy; d_oe = jb_oe; d_data = rx_data;
                        fin = 1;
                    end else if (++bud > Budget) begin
                        fin = 1;
                    end
                end
            end
            begin
                if (v.n_dev > 0) begin
                    while (!fin && runs.size() < 8 * v.tx_len + 1) @(negedge clock);
                    if (!fin) begin
                        repeat (30) @(negedge clock);
                        if (v.glitch) pulse(2, 98);
                        for (int i = 0; i < v.n_dev; i++) begin
                            b = byte_of(v.dev, i);
                            for (int j = 7; j >= 0; j--) begin
                                d = b[j] ? v.lw1 : v.lw0;
                                pulse(d, 200 - d);
                            end
                        end
                        pulse(50, 100);
                    end
                end
            end
        join
        dev_drive = 1'b0;

        chk({name, ":done_seen"}, int'(done_seen), 1);
        if (v.tx_len > 0) begin
            chk({name, ":tx_runs"}, runs.size(), 8 * v.tx_len + 1);
            werr = 0;
            for (int i = 0; i < runs.size() && i < 8 * v.tx_len + 1; i++) begin
                b = byte_of(v.tx, i / 8);
                want_w = (i == 8 * v.tx_len) ? 50 : (b[7 - (i % 8)] ? 50 : 150);
                if (runs[i] != want_w) werr++;
                if (i > 0 && starts[i] - starts[i-1] != 200) werr++;
            end
            chk({name, ":tx_shape_errs"}, werr, 0);
            chk({name, ":ack_count"}, acks.size(), v.tx_len);
            aerr = 0;
            if (acks.size() > 0 && starts.size() > 0 && acks[0] != starts[0]) aerr++;
            for (int i = 1; i < acks.size(); i++) if (acks[i] - acks[i-1] != 1600) aerr++;
            chk({name, ":ack_timing_errs"}, aerr, 0);
        end else begin
            chk({name, ":zero_len_latency"}, done_cyc - start_cyc, 1);
            chk({name, ":zero_len_busy"}, int'(busy_ever), 0);
            chk({name, ":zero_len_line"}, runs.size(), 0);
        end
        chk({name, ":rx_count"}, d_count, v.exp_count);
        chk({name, ":timeout_err"}, int'(d_err), int'(v.exp_err));
        chk({name, ":busy_at_done"}, int'(d_busy), 0);
        chk({name, ":oe_at_done"}, int'(d_oe), 0);
        chk({name, ":rx_valid_count"}, rxq.size(), expq.size());
        werr = 0;
        for (int i = 0; i < rxq.size() && i < expq.size(); i++) if (rxq[i] !== expq[i]) werr++;
        chk({name, ":rx_byte_errs"}, werr, 0);
        if (v.exp_count > 0) chk({name, ":rx_data"}, int'(d_data), int'(v.exp_last));
        if (v.tx_len > 0 && v.rx_len == 0) chk({name, ":stop_wait"}, done_cyc - rel_cyc, 100);
        if (v.tx_len > 0 && v.rx_len > 0 && v.n_dev == 0) begin
            d = done_cyc - rel_cyc;
            total++;
            if (d < 3197 || d > 3203) begin
                bad++;
                $display("FAIL %s:timeout_window: got=%0d want=3200+-3", name, d);
            end
        end
        repeat (20) @(negedge clock);
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        tbl[0] = '{1, 24'h000000, 3, 3, 24'h050002, 50, 150, 0, 0, 3, 0, 8'h02};
        tbl[1] = '{1, 24'h010000, 4, 0, 24'h000000, 50, 150, 0, 0, 0, 1, 8'h00};
        tbl[2] = '{1, 24'h120000, 1, 1, 24'hA50000, 50, 150, 0, 0, 1, 0, 8'hA5};
        tbl[3] = '{1, 24'h120000, 1, 1, 24'h3C0000, 99, 100, 0, 0, 1, 0, 8'h3C};
        tbl[4] = '{3, 24'h028001, 1, 1, 24'h5A0000, 50, 150, 0, 1, 1, 0, 8'h5A};
        tbl[5] = '{0, 24'h000000, 2, 0, 24'h000000, 50, 150, 0, 0, 0, 0, 8'h00};
        tbl[6] = '{1, 24'h030000, 2, 1, 24'h770000, 50, 150, 0, 0, 1, 1, 8'h77};
        tbl[7] = '{1, 24'h000000, 1, 1, 24'h000000, 50, 150, 1, 0, 1, 0,
                   FiltOn ? 8'h00 : 8'h80};
        tbl[8] = '{1, 24'hFF0000, 0, 0, 24'h000000, 50, 150, 0, 0, 0, 0, 8'h00};

        repeat (3) @(negedge clock);
        chk("reset:jb_oe", int'(jb_oe), 0);
        chk("reset:busy", int'(busy), 0);
        chk("reset:done", int'(done), 0);
        chk("reset:tx_ack", int'(tx_ack), 0);
        chk("reset:rx_valid", int'(rx_valid), 0);
        chk("reset:timeout_err", int'(timeout_err), 0);
        chk("reset:rx_data", int'(rx_data), 0);
        chk("reset:rx_count", int'(rx_count), 0);
        reset_l = 1'b1;
        repeat (5) @(negedge clock);

        for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 4; i++) begin
            rv.tx_len = int'($urandom_range(1, 2));
            rv.tx     = 24'($urandom());
            rv.rx_len = int'($urandom_range(1, 2));
            rv.n_dev  = ($urandom_range(0, 3) == 0) ? rv.rx_len - 1 : rv.rx_len;
            rv.dev    = 24'($urandom());
            rv.lw1    = int'($urandom_range(20, 99));
            rv.lw0    = int'($urandom_range(100, 180));
            rv.glitch = 1'b0;
            rv.poke   = 1'b0;
            model(rv);
            rv.exp_count = m_cnt;
            rv.exp_err   = m_err;
            rv.exp_last  = (m_cnt > 0) ? expq[m_cnt-1] : 8'h00;
            run_txn(rv, $sformatf("rand%0d", i));
        end

        // Asynchronous reset in the middle of a transmitted 0 bit must release the line at once.
        @(negedge clock);
        tx_len = 6'd1; rx_len = 6'd0; tx_data = 8'h00; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (299) @(negedge clock);
        chk("midreset:oe_before", int'(jb_oe), 1);
        chk("midreset:busy_before", int'(busy), 1);
        reset_l = 1'b0;
        #1;
        chk("midreset:oe_after", int'(jb_oe), 0);
        chk("midreset:busy_after", int'(busy), 0);
        @(negedge clock);
        reset_l = 1'b1;
        repeat (10) @(negedge clock);
        chk("midreset:idle_oe", int'(jb_oe), 0);
        chk("midreset:idle_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
